// File: rtl/ft245_async_if.sv
// FT245 asynchronous FIFO bridge: arbitrates between draining the FT245 RX
// FIFO into a valid/ready stream and pushing a valid/ready stream into the
// FT245 TX FIFO, generating rd_n/wr_n strobes with programmable widths.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | bus released, choosing next transfer direction
// S_RD_LOW   | rd_n low, FT245 drives the bus; capture on last cycle
// S_WR_SETUP | bus driven with latched word, wr_n still high
// S_WR_LOW   | bus driven, wr_n low
// S_WR_HOLD  | bus driven, wr_n back high
// S_TURN     | both strobes high, bus released before next decision
module ft245_async_if #(
  parameter int WIDTH       = 8,
  parameter int RD_CYCLES   = 3,
  parameter int WR_CYCLES   = 3,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] data_io,
  input  logic             rxf_n,
  input  logic             txe_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ?
                           ((RD_CYCLES > TURN_CYCLES) ? RD_CYCLES : TURN_CYCLES) :
                           ((WR_CYCLES > TURN_CYCLES) ? WR_CYCLES : TURN_CYCLES);
  localparam int CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] RD_LOAD   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LOAD   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LOW,
    S_WR_SETUP,
    S_WR_LOW,
    S_WR_HOLD,
    S_TURN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_rxf_meta, r_rxf_s;
  logic             r_txe_meta, r_txe_s;
  logic             r_last_tx;
  logic             r_rd_n, r_wr_n, r_oe;
  logic [WIDTH-1:0] r_tx_word;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;

  logic             w_rx_take;
  logic             w_rx_elig;
  logic             w_tx_elig;
  logic             w_pick_rx;
  logic             w_pick_tx;
  logic             w_capture;

  assign w_rx_take = r_rx_valid & rx_ready;
  assign w_rx_elig = ~r_rxf_s & (~r_rx_valid | w_rx_take);
  assign w_tx_elig = ~r_txe_s & tx_valid;

  assign data_io  = r_oe ? r_tx_word : {WIDTH{1'bz}};
  assign rd_n     = r_rd_n;
  assign wr_n     = r_wr_n;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  // Gated by reset so no acceptance can be signalled while the block is held.
  assign tx_ready = rst_n & w_pick_tx;

  // Two-flop synchronisers for the asynchronous FT245 flags; idle-high on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxf_meta <= 1'b1;
      r_rxf_s    <= 1'b1;
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
    end else begin
      r_rxf_meta <= rxf_n;
      r_rxf_s    <= r_rxf_meta;
      r_txe_meta <= txe_n;
      r_txe_s    <= r_txe_meta;
    end
  end

  // Next-state, arbitration and down-counter reload/terminal-count decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pick_rx   = 1'b0;
    w_pick_tx   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the direction not served last wins.
        if (w_rx_elig && (!w_tx_elig || r_last_tx)) begin
          w_pick_rx   = 1'b1;
          w_state_nxt = S_RD_LOW;
          w_cnt_nxt   = RD_LOAD;
        end else if (w_tx_elig) begin
          w_pick_tx   = 1'b1;
          w_state_nxt = S_WR_SETUP;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      S_RD_LOW: begin
        if (r_cnt == CNT_ZERO) begin
          w_capture   = 1'b1;
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TURN_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_WR_SETUP: begin
        w_state_nxt = S_WR_LOW;
        w_cnt_nxt   = WR_LOAD;
      end
      S_WR_LOW: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_WR_HOLD: begin
        w_state_nxt = S_TURN;
        w_cnt_nxt   = TURN_LOAD;
      end
      S_TURN: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State register plus strobes/output-enable registered from the next state
  // so the FT245 pins never see decode glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_last_tx  <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_tx_word  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_n  <= (w_state_nxt != S_RD_LOW);
      r_wr_n  <= (w_state_nxt != S_WR_LOW);
      r_oe    <= (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_LOW) ||
                 (w_state_nxt == S_WR_HOLD);
      if (w_pick_rx) begin
        r_last_tx <= 1'b0;
      end
      if (w_pick_tx) begin
        r_last_tx <= 1'b1;
        r_tx_word <= tx_data;
      end
      // A capture coinciding with consumption keeps valid high with the new word.
      if (w_capture) begin
        r_rx_data  <= data_io;
        r_rx_valid <= 1'b1;
      end else if (w_rx_take) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ft245_async_if.sv
// Bench for ft245_async_if: default instance and a WIDTH=16/1/1/2 instance,
// exercised one at a time with a shared stimulus/scoreboard process.
module tb_ft245_async_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxf_n, txe_n, rx_ready, tx_valid;
  logic [15:0] tx_data, ft_word;
  logic        sel;

  always #5 clk = ~clk;

  // instance A: default parameters
  wire  [7:0]  bus_a;
  logic        rd_n_a, wr_n_a, rx_valid_a, tx_ready_a;
  logic [7:0]  rx_data_a;
  wire         rxf_n_a    = sel ? 1'b1 : rxf_n;
  wire         txe_n_a    = sel ? 1'b1 : txe_n;
  wire         tx_valid_a = sel ? 1'b0 : tx_valid;
  wire  [7:0]  tx_data_a  = tx_data[7:0];
  assign bus_a = (!rd_n_a) ? ft_word[7:0] : 8'hzz;

  ft245_async_if dut_a (
    .clk(clk), .rst_n(rst_n), .data_io(bus_a), .rxf_n(rxf_n_a), .txe_n(txe_n_a),
    .rd_n(rd_n_a), .wr_n(wr_n_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a)
  );

  // instance B: scaled timings
  wire  [15:0] bus_b;
  logic        rd_n_b, wr_n_b, rx_valid_b, tx_ready_b;
  logic [15:0] rx_data_b;
  wire         rxf_n_b    = sel ? rxf_n : 1'b1;
  wire         txe_n_b    = sel ? txe_n : 1'b1;
  wire         tx_valid_b = sel ? tx_valid : 1'b0;
  assign bus_b = (!rd_n_b) ? ft_word : 16'hzzzz;

  ft245_async_if #(.WIDTH(16), .RD_CYCLES(1), .WR_CYCLES(1), .TURN_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_io(bus_b), .rxf_n(rxf_n_b), .txe_n(txe_n_b),
    .rd_n(rd_n_b), .wr_n(wr_n_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b)
  );

  wire        m_rd_n     = sel ? rd_n_b : rd_n_a;
  wire        m_wr_n     = sel ? wr_n_b : wr_n_a;
  wire        m_rx_valid = sel ? rx_valid_b : rx_valid_a;
  wire        m_tx_ready = sel ? tx_ready_b : tx_ready_a;
  wire [15:0] m_bus      = sel ? bus_b : {8'h00, bus_a};
  wire [15:0] m_rx_data  = sel ? rx_data_b : {8'h00, rx_data_a};

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          rd_cyc, wr_cyc, turn_cyc;
  logic [15:0] mask;
  logic [15:0] rx_q[$];
  logic [15:0] tx_q[$];
  int          dir_log[$];
  int          tx_left;
  bit          tx_hs_pending;

  logic        prev_rd, prev_wr, prev_rxv;
  logic [15:0] prev_bus;
  int          n_rd, n_wr, n_rx_hs, n_tx_hs;
  int          rd_len, wr_len, rd_start_cyc, wr_start_cyc, rxv_rise_cyc;
  int          rx_hs_cyc, txr_cyc, last_end_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, sel %0d)", tag, got, exp, cyc, sel);
    end
  endtask

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_rx_hs = 0; n_tx_hs = 0;
    rd_len = 0; wr_len = 0;
    rd_start_cyc = -1; wr_start_cyc = -1; rxv_rise_cyc = -1;
    rx_hs_cyc = -1; txr_cyc = -1; last_end_cyc = -1;
    dir_log.delete();
  endtask

  // One clock: sample 1ns before the rising edge, run the scoreboard/monitor,
  // then return at the falling edge where the caller may change inputs.
  task automatic cycle();
    logic        s_rd, s_wr, s_rxv, s_txr;
    logic [15:0] s_bus, s_rxd, exp_w;
    #4;
    s_rd = m_rd_n; s_wr = m_wr_n; s_rxv = m_rx_valid; s_txr = m_tx_ready;
    s_bus = m_bus; s_rxd = m_rx_data;
    if (!rst_n) begin
      s_rd = 1'b1; s_wr = 1'b1; s_rxv = 1'b0;
    end else begin
      if (!s_rd || !s_wr) begin
        check_val("strobe_excl", s_rd | s_wr, 1);
        check_val("txr_busy", s_txr, 0);
      end
      if (!s_rd && prev_rd) begin
        n_rd++; rd_start_cyc = cyc; rd_len = 0;
        dir_log.push_back(0);
        if (last_end_cyc >= 0) check_val("turn_gap", (cyc - last_end_cyc) >= turn_cyc + 1, 1);
        rx_q.push_back(ft_word & mask);
      end
      if (!s_rd) rd_len++;
      if (s_rd && !prev_rd) begin
        check_val("rd_len", rd_len, rd_cyc);
        last_end_cyc = cyc;
        ft_word = ft_word + 16'h1111;
      end
      exp_w = (tx_q.size() != 0) ? tx_q[0] : 16'h0;
      if (!s_wr && prev_wr) begin
        check_val("wr_queued", tx_q.size() != 0, 1);
        check_val("wr_setup", prev_bus, exp_w);
        n_wr++; wr_start_cyc = cyc; wr_len = 0;
        dir_log.push_back(1);
        if (last_end_cyc >= 0) check_val("turn_gap", (cyc - last_end_cyc) >= turn_cyc + 1, 1);
      end
      if (!s_wr) begin
        wr_len++;
        check_val("wr_data", s_bus, exp_w);
      end
      if (s_wr && !prev_wr) begin
        check_val("wr_len", wr_len, wr_cyc);
        check_val("wr_hold", s_bus, exp_w);
        if (tx_q.size() != 0) void'(tx_q.pop_front());
        last_end_cyc = cyc + 1;
      end
      if (s_rxv && !prev_rxv) rxv_rise_cyc = cyc;
      if (s_rxv && rx_ready) begin
        check_val("rx_queued", rx_q.size() != 0, 1);
        check_val("rx_data", s_rxd, (rx_q.size() != 0) ? rx_q.pop_front() : 16'h0);
        n_rx_hs++; rx_hs_cyc = cyc;
      end
      if (s_txr && tx_valid) begin
        tx_q.push_back(tx_data & mask);
        n_tx_hs++; txr_cyc = cyc;
        tx_hs_pending = 1'b1;
      end
    end
    prev_rd = s_rd; prev_wr = s_wr; prev_rxv = s_rxv; prev_bus = s_bus;
    @(negedge clk);
    cyc++;
    if (tx_hs_pending) begin
      tx_hs_pending = 1'b0;
      tx_left--;
      if (tx_left <= 0) tx_valid = 1'b0;
      else tx_data = tx_data + 16'h0107;
    end
  endtask

  task automatic reset_hold(input int n, input bit chk);
    rst_n = 1'b0;
    if (chk) begin
      tx_valid = 1'b1; txe_n = 1'b0; tx_data = 16'h7E7E;
    end
    repeat (n) cycle();
    if (chk) begin
      check_val("rst_rd_n", m_rd_n, 1);
      check_val("rst_wr_n", m_wr_n, 1);
      check_val("rst_rx_valid", m_rx_valid, 0);
      check_val("rst_tx_ready", m_tx_ready, 0);
    end
  endtask

  task automatic reset_release();
    tx_valid = 1'b0; txe_n = 1'b1; rxf_n = 1'b1; rx_ready = 1'b1;
    tx_left = 0; tx_hs_pending = 1'b0;
    rx_q.delete(); tx_q.delete();
    clear_mon();
    rst_n = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_read(input logic [15:0] w);
    int t0;
    clear_mon();
    rx_ready = 1'b1; ft_word = w;
    t0 = cyc; rxf_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n_rd >= 1) rxf_n = 1'b1;
    end
    check_val("rd_count", n_rd, 1);
    check_val("rd_latency", rd_start_cyc - t0, 3);
    check_val("rxv_latency", rxv_rise_cyc - t0, 3 + rd_cyc);
    check_val("rx_hs_count", n_rx_hs, 1);
    check_val("rxq_empty", rx_q.size(), 0);
  endtask

  task automatic test_write(input logic [15:0] w);
    int t0;
    clear_mon();
    tx_data = w; tx_left = 1; tx_valid = 1'b1;
    t0 = cyc; txe_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n_wr >= 1) txe_n = 1'b1;
    end
    check_val("txr_latency", txr_cyc - t0, 2);
    check_val("tx_hs_count", n_tx_hs, 1);
    check_val("wr_latency", wr_start_cyc - t0, 4);
    check_val("wr_count", n_wr, 1);
    check_val("txq_empty", tx_q.size(), 0);
  endtask

  task automatic test_backpressure();
    clear_mon();
    rx_ready = 1'b0; ft_word = 16'h5A96; rxf_n = 1'b0;
    repeat (25) cycle();
    check_val("bp_one_read", n_rd, 1);
    check_val("bp_held_valid", m_rx_valid, 1);
    check_val("bp_no_hs", n_rx_hs, 0);
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && n_rd < 2; i++) cycle();
    check_val("bp_second_read", n_rd, 2);
    check_val("bp_back_to_back", rd_start_cyc - rx_hs_cyc, 1);
    rxf_n = 1'b1;
    repeat (20) cycle();
    check_val("bp_hs_count", n_rx_hs, 2);
    check_val("bp_rxq_empty", rx_q.size(), 0);
  endtask

  task automatic test_contention();
    reset_hold(3, 1'b0);
    reset_release();
    rx_ready = 1'b1; tx_data = 16'hC381; tx_left = 1000; tx_valid = 1'b1;
    ft_word = 16'h1357; rxf_n = 1'b0; txe_n = 1'b0;
    for (int i = 0; i < 80 && dir_log.size() < 4; i++) cycle();
    rxf_n = 1'b1; txe_n = 1'b1; tx_valid = 1'b0;
    repeat (30) cycle();
    for (int i = 0; i < 4; i++)
      check_val($sformatf("alt_dir%0d", i), (i < dir_log.size()) ? dir_log[i] : 2, i % 2);
    check_val("cont_rxq_empty", rx_q.size(), 0);
    check_val("cont_txq_empty", tx_q.size(), 0);
  endtask

  task automatic test_reset_mid_write();
    reset_hold(2, 1'b0);
    reset_release();
    rx_ready = 1'b0; ft_word = 16'h0F1E;
    tx_data = 16'h5AC3; tx_left = 1; tx_valid = 1'b1;
    rxf_n = 1'b0; txe_n = 1'b0;
    for (int i = 0; i < 40 && prev_wr != 1'b0; i++) cycle();
    check_val("wr_low_reached", prev_wr, 0);
    check_val("rd_before_wr", n_rd, 1);
    rst_n = 1'b0;
    cycle();
    check_val("mid_rst_wr_n", m_wr_n, 1);
    check_val("mid_rst_rd_n", m_rd_n, 1);
    check_val("mid_rst_tx_ready", m_tx_ready, 0);
    check_val("mid_rst_rx_drop", m_rx_valid, 0);
    reset_release();
    test_read(16'h6699);
  endtask

  initial begin
    rst_n = 1'b0; rxf_n = 1'b1; txe_n = 1'b1; rx_ready = 1'b1; tx_valid = 1'b0;
    tx_data = 16'h0; ft_word = 16'h0; sel = 1'b0; mask = 16'h00FF;
    rd_cyc = 3; wr_cyc = 3; turn_cyc = 1;
    tx_left = 0; tx_hs_pending = 1'b0;
    prev_rd = 1'b1; prev_wr = 1'b1; prev_rxv = 1'b0; prev_bus = 16'h0;
    clear_mon();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      if (s == 1) begin
        mask = 16'hFFFF; rd_cyc = 1; wr_cyc = 1; turn_cyc = 2;
      end else begin
        mask = 16'h00FF; rd_cyc = 3; wr_cyc = 3; turn_cyc = 1;
      end
      reset_hold(3, 1'b1);
      reset_release();
      test_read(16'hA5A5);
      test_write(16'h3C3C);
      test_backpressure();
      test_contention();
      test_reset_mid_write();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
